// File: rtl/adder_bcd_display.sv
// Adds two unsigned switch operands and shows the sum on a multiplexed
// seven-segment display, in hexadecimal or decimal (double-dabble BCD).
// A conversion is launched whenever the registered operands or mode change.
module adder_bcd_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              mode,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp,
  output logic              carry,
  output logic              busy
);

  localparam int SW    = WIDTH + 1;
  localparam int BCD_N = SW / 3 + 1;
  localparam int HEX_N = (SW + 3) / 4;
  localparam int NN    = (BCD_N > HEX_N) ? BCD_N : HEX_N;
  localparam int ND    = (NN > DIGITS) ? NN : DIGITS;
  localparam int CW    = $clog2(SW);
  localparam int PRW   = $clog2(REFRESH_DIV);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in a bit.
  function automatic logic [4*NN-1:0] dd_step(input logic [4*NN-1:0] bcd,
                                               input logic bit_in);
    logic [4*NN-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NN; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[4*NN-2:0], bit_in};
  endfunction

  // Active-low segment pattern; bit 4 of the code requests a blank digit.
  function automatic logic [6:0] seg_enc(input logic [4:0] code);
    logic [6:0] s;
    if (code[4]) begin
      s = 7'h7F;
    end else begin
      case (code[3:0])
        4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
        4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
        4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
        4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
    end
    return s;
  endfunction

  // Input stage and conversion datapath (no reset needed)
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [SW-1:0]    sum_q, sum_d, bin_q, bin_d;
  logic [4*NN-1:0]  bcd_q, bcd_d;

  // Control state
  state_t           state_q, state_d;
  logic [WIDTH-1:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic             snap_mode_q, snap_mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       dig_q [DIGITS];
  logic [4:0]       dig_d [DIGITS];
  logic             trunc_q, trunc_d, carry_q, carry_d, busy_q, busy_d;
  logic [PRW-1:0]   presc_q, presc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic             dp_q, dp_d;

  // Result unpacking helpers
  logic [4*ND-1:0]  src_w;
  logic             seen_w, ld_trunc;
  logic [4:0]       ld_dig [DIGITS];
  logic             start_w;

  // Pick hex nibbles or BCD digits of the finished conversion, with blanking and truncation
  always_comb begin
    src_w    = snap_mode_q ? (4*ND)'(bcd_q) : (4*ND)'(sum_q);
    seen_w   = 1'b0;
    ld_trunc = 1'b0;
    for (int i = ND - 1; i >= DIGITS; i--) begin
      seen_w   = seen_w | (src_w[4*i +: 4] != 4'd0);
      ld_trunc = ld_trunc | (src_w[4*i +: 4] != 4'd0);
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_w    = seen_w | (src_w[4*i +: 4] != 4'd0);
      ld_dig[i] = {snap_mode_q & ~seen_w & (i != 0), src_w[4*i +: 4]};
    end
  end

  // Next-state logic: conversion FSM, scan counters and output patterns
  always_comb begin
    state_d     = state_q;
    snap_a_d    = snap_a_q;
    snap_b_d    = snap_b_q;
    snap_mode_d = snap_mode_q;
    sum_d       = sum_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    dig_d       = dig_q;
    trunc_d     = trunc_q;
    carry_d     = carry_q;

    // A pending change launched from LOAD keeps busy high with no idle gap.
    start_w = (state_q != CONV) &&
              ({a_q, b_q, mode_q} != {snap_a_q, snap_b_q, snap_mode_q});

    case (state_q)
      CONV: begin
        bin_d = {bin_q[SW-2:0], 1'b0};
        bcd_d = dd_step(bcd_q, bin_q[SW-1]);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SW - 1)) state_d = LOAD;
      end
      LOAD: begin
        dig_d   = ld_dig;
        trunc_d = ld_trunc;
        carry_d = sum_q[SW-1];
        state_d = IDLE;
      end
      default: ;
    endcase

    if (start_w) begin
      state_d     = CONV;
      snap_a_d    = a_q;
      snap_b_d    = b_q;
      snap_mode_d = mode_q;
      sum_d       = {1'b0, a_q} + {1'b0, b_q};
      bin_d       = {1'b0, a_q} + {1'b0, b_q};
      bcd_d       = '0;
      cnt_d       = '0;
    end

    busy_d = (state_d != IDLE);

    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Outputs follow the next digit register so new results appear on the LOAD edge.
    an_d  = ~(DIGITS'(1) << idx_d);
    seg_d = seg_enc(dig_d[idx_d]);
    dp_d  = ~((idx_d == '0) & trunc_d);
  end

  // Input stage and conversion datapath registers
  always_ff @(posedge clk) begin
    a_q    <= A;
    b_q    <= B;
    mode_q <= mode;
    sum_q  <= sum_d;
    bin_q  <= bin_d;
    bcd_q  <= bcd_d;
  end

  // Control, result and display registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_a_q    <= '0;
      snap_b_q    <= '0;
      snap_mode_q <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < DIGITS; i++) dig_q[i] <= '0;
      trunc_q     <= 1'b0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      presc_q     <= '0;
      idx_q       <= '0;
      seg_q       <= 7'h7F;
      an_q        <= '1;
      dp_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      snap_a_q    <= snap_a_d;
      snap_b_q    <= snap_b_d;
      snap_mode_q <= snap_mode_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      trunc_q     <= trunc_d;
      carry_q     <= carry_d;
      busy_q      <= busy_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign carry = carry_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_adder_bcd_display.sv
// Directed bench for adder_bcd_display: a 4-digit and a 2-digit instance.
module tb_adder_bcd_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, a2, b2;
  logic       mode, mode2;
  logic [6:0] seg, seg2;
  logic [3:0] an;
  logic [1:0] an2;
  logic       dp, dp2, carry, carry2, busy, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_bcd_display #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .mode(mode),
    .seg(seg), .an(an), .dp(dp), .carry(carry), .busy(busy)
  );

  adder_bcd_display #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .A(a2), .B(b2), .mode(mode2),
    .seg(seg2), .an(an2), .dp(dp2), .carry(carry2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for digit i of the 4-digit display to be selected, then check its segments.
  task automatic show1(input int i, input logic [6:0] exp_seg, input string tag);
    logic [3:0] want;
    int n;
    want = 4'b0001 << i;
    want = ~want;
    n = 0;
    while (an !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else         chk(tag, {25'd0, seg}, {25'd0, exp_seg});
  endtask

  // Same for the 2-digit display, also checking the decimal point.
  task automatic show2(input int i, input logic [6:0] exp_seg, input logic exp_dp,
                       input string tag);
    logic [1:0] want;
    int n;
    want = 2'b01 << i;
    want = ~want;
    n = 0;
    while (an2 !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk(tag, {25'd0, seg2}, {25'd0, exp_seg});
      chk({tag, "_dp"}, {31'd0, dp2}, {31'd0, exp_dp});
    end
  endtask

  initial begin
    logic [3:0] seq [4];
    int n;
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

    // Reset with all operands zero
    rst = 1'b1; a = 8'd0; b = 8'd0; mode = 1'b0;
    a2 = 8'd0; b2 = 8'd0; mode2 = 1'b0;
    tick(2);
    chk("rst_an",   {28'd0, an},  32'hF);
    chk("rst_seg",  {25'd0, seg}, 32'h7F);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dp",   {31'd0, dp},  32'd1);

    rst = 1'b0;
    tick(1);
    chk("rel_an",   {28'd0, an},  32'hE);
    chk("rel_seg",  {25'd0, seg}, 32'h40);
    chk("rel_busy", {31'd0, busy}, 32'd0);
    tick(3);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Scan sequence: each anode held exactly four cycles
    n = 0;
    while (an !== 4'b1110 && n < 40) begin tick(1); n++; end
    while (an === 4'b1110 && n < 40) begin tick(1); n++; end
    chk("scan_sync", {31'd0, (n < 40)}, 32'd1);
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 4; c++) begin
        chk("scan_an", {28'd0, an}, {28'd0, seq[j]});
        tick(1);
      end
    end

    // Hex FF + 01 = 0x100, busy for 10 cycles
    a = 8'hFF; b = 8'h01;
    tick(1);
    chk("hex_busy_k",   {31'd0, busy}, 32'd0);
    tick(1);
    chk("hex_busy_k1",  {31'd0, busy}, 32'd1);
    tick(9);
    chk("hex_busy_k10", {31'd0, busy}, 32'd1);
    tick(1);
    chk("hex_busy_k11", {31'd0, busy}, 32'd0);
    chk("hex_carry",    {31'd0, carry}, 32'd1);
    show1(0, 7'h40, "hex_d0");
    chk("hex_dp", {31'd0, dp}, 32'd1);
    show1(1, 7'h40, "hex_d1");
    show1(2, 7'h79, "hex_d2");
    show1(3, 7'h40, "hex_d3");

    // Decimal 200 + 55 = 255, digit 3 blanked
    mode = 1'b1; a = 8'd200; b = 8'd55;
    tick(12);
    chk("dec_busy",  {31'd0, busy},  32'd0);
    chk("dec_carry", {31'd0, carry}, 32'd0);
    show1(0, 7'h12, "dec_d0");
    show1(1, 7'h12, "dec_d1");
    show1(2, 7'h24, "dec_d2");
    show1(3, 7'h7F, "dec_d3");

    // Same operands in hex: 00FF
    mode = 1'b0;
    tick(12);
    show1(0, 7'h0E, "tog_d0");
    show1(1, 7'h0E, "tog_d1");
    show1(2, 7'h40, "tog_d2");
    show1(3, 7'h40, "tog_d3");

    // Preset a carry, then change B during conversion
    a = 8'hFF; b = 8'h01;
    tick(12);
    chk("pre_carry", {31'd0, carry}, 32'd1);
    a = 8'hFE;
    tick(4);
    b = 8'h02;
    tick(7);
    chk("mid_carry_k10", {31'd0, carry}, 32'd1);
    chk("mid_busy_k10",  {31'd0, busy},  32'd1);
    tick(1);
    chk("mid_carry_k11", {31'd0, carry}, 32'd0);
    chk("mid_busy_k11",  {31'd0, busy},  32'd1);
    tick(9);
    chk("mid_carry_k20", {31'd0, carry}, 32'd0);
    chk("mid_busy_k20",  {31'd0, busy},  32'd1);
    tick(1);
    chk("mid_carry_k21", {31'd0, carry}, 32'd1);
    chk("mid_busy_k21",  {31'd0, busy},  32'd0);
    show1(2, 7'h79, "mid_d2");
    show1(0, 7'h40, "mid_d0");

    // Reset in the middle of a conversion
    a = 8'h12; b = 8'h34;
    tick(5);
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1; a = 8'd0; b = 8'd0;
    tick(1);
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_an",    {28'd0, an},    32'hF);
    chk("abort_seg",   {25'd0, seg},   32'h7F);
    chk("abort_carry", {31'd0, carry}, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("abort_rel_an",  {28'd0, an},  32'hE);
    chk("abort_rel_seg", {25'd0, seg}, 32'h40);
    show1(1, 7'h40, "abort_d1");
    show1(2, 7'h40, "abort_d2");
    show1(3, 7'h40, "abort_d3");
    chk("abort_busy_after", {31'd0, busy}, 32'd0);

    // Two-digit display: 99 + 1 = 100 truncated to 00
    mode2 = 1'b1; a2 = 8'd99; b2 = 8'd1;
    tick(12);
    chk("trunc_busy",  {31'd0, busy2},  32'd0);
    chk("trunc_carry", {31'd0, carry2}, 32'd0);
    show2(0, 7'h40, 1'b0, "trunc_d0");
    show2(1, 7'h40, 1'b1, "trunc_d1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_bcd_display.md
ADDER_BCD_DISPLAY -- requirements
Module: adder_bcd_display

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (>=4).
REQ-002 Parameter DIGITS, default 4, number of seven-segment digits driven (>=1).
REQ-003 Parameter REFRESH_DIV, default 100000, clock cycles per digit scan slot (>=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 A  input  WIDTH  operand A, unsigned, asynchronous to clk (switches).
REQ-007 B  input  WIDTH  operand B, unsigned.
REQ-008 mode  input  1  0 = hexadecimal display, 1 = decimal display.
REQ-009 seg  output  7  segment cathodes, active-low, seg[0]=a .. seg[6]=g.
REQ-010 an  output  DIGITS  digit anodes, active-low, one-hot-low when scanning.
REQ-011 dp  output  1  decimal point, active-low; lit = result truncated.
REQ-012 carry  output  1  active-high carry-out of A+B for the displayed result.
REQ-013 busy  output  1  high while a conversion is in progress.

Function
REQ-014 A, B, mode SHALL be registered every edge (input stage); all downstream logic uses registered copies only.
REQ-015 Sum SHALL be A+B computed at WIDTH+1 bits, unsigned, no wrap.
REQ-016 FSM states IDLE, CONV, LOAD; IDLE->CONV when registered {A,B,mode} differs from the stored snapshot, snapshot captured on that edge.
REQ-017 CONV SHALL last exactly WIDTH+1 cycles, performing one shift-add-3 (double-dabble) step per cycle on the snapshot sum; CONV->LOAD after the last step.
REQ-018 LOAD SHALL last one cycle and write the digit register, carry, and truncation flag on its closing edge; LOAD->IDLE.
REQ-019 Input change seen at input-stage edge k SHALL update displayed digits on edge k+WIDTH+3; busy high from edge k+1 to edge k+WIDTH+3.
REQ-020 Hex mode: digit i = sum nibble i; uniform CONV timing kept; no leading-zero blanking.
REQ-021 Decimal mode: digit i = BCD digit i; leading zeros above the highest non-zero digit blanked (seg=1111111); digit 0 never blanked.
REQ-022 Truncation flag SHALL be set when non-zero nibbles/BCD digits exist at index >=DIGITS; dp driven low only while digit 0 is selected and flag set.
REQ-023 Operand changes during CONV/LOAD SHALL be ignored for the current conversion and re-trigger from IDLE afterwards.
REQ-024 Scan: prescaler counts 0..REFRESH_DIV-1; on wrap, digit index advances, DIGITS-1 wraps to 0; an=~(1<<index).
REQ-025 seg SHALL encode 0-F standard (0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110); seg, an, dp registered.

Reset
REQ-026 While rst high on an edge: FSM=IDLE, snapshot={0,0,0}, digit register all 0, truncation flag 0, carry 0, prescaler 0, index 0, busy 0.
REQ-027 Outputs during reset: an all 1, seg=1111111, dp=1; on first edge after release an=~1 showing digit 0.
REQ-028 Reset asserted mid-CONV SHALL abort the conversion; no partial result displayed.

Verification (WIDTH=8, DIGITS=4, REFRESH_DIV=4 unless noted)
REQ-029 rst high 2 cycles, A=B=0, mode=0 -> an=1111, seg=1111111, busy=0 in reset; after release an=1110, seg=1000000, no conversion started.
REQ-030 mode=0, A=0xFF, B=0x01 -> busy high 10 cycles, then digits 0,1,0,0 (digit2 seg=1111001), carry=1, dp=1.
REQ-031 mode=1, A=200, B=55 -> digits 2,5,5 on an index 2..0, digit3 blank, carry=0; mode toggled to 0 -> reconverts, shows 00FF.
REQ-032 DIGITS=2, mode=1, A=99, B=1 -> displays 00, dp=0 during digit-0 slot only.
REQ-033 Change B from 1 to 2 three cycles into CONV -> first result (A+1) displayed, busy stays high/reasserts, A+2 displayed WIDTH+2 cycles later.
REQ-034 Steady state -> an sequence 1110,1101,1011,0111,1110, each held exactly 4 cycles; rst pulse mid-CONV -> busy=0 next edge, display 0000.
